// File: rtl/pb_press_decoder.sv
// ============================================================================
// Module  : pb_press_decoder
// Brief   : Turns the debouncer toggle flag into press pulses, a press count
//           and single/double-press classification. Optional macro:
//           PB_PRESS_DOUBLE_EN enables the windowed single/double classifier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pb_press_decoder #(
  parameter int WINDOW_CYCLES = 4000000,
  parameter int WIN_W         = 22,
  parameter int CNT_W         = 8
) (
  input  logic             clk_16M,
  input  logic             rst_n,
  input  logic             set_rst_flag,
  output logic             press_pulse,
  output logic             single_press,
  output logic             double_press,
  output logic [CNT_W-1:0] press_count
);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             primed_q, primed_d;
  logic             press_pulse_q, press_pulse_d;
  logic [CNT_W-1:0] press_count_q, press_count_d;
  logic             single_press_q, single_press_d;
  logic             double_press_q, double_press_d;
  logic             ev;

  // The first edge after reset loads both stages from the flag, so a flag
  // that is already high out of reset never looks like a press.
  always_comb begin
    s1_d     = set_rst_flag;
    s2_d     = s1_q;
    primed_d = 1'b1;
    if (!primed_q) begin
      s2_d = set_rst_flag;
    end
  end

  assign ev = primed_q & (s1_q ^ s2_q);

  always_comb begin
    press_pulse_d = ev;
    press_count_d = press_count_q;
    if (ev) begin
      press_count_d = press_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_16M or negedge rst_n) begin
    if (!rst_n) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      primed_q      <= 1'b0;
      press_pulse_q <= 1'b0;
      press_count_q <= '0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      primed_q      <= primed_d;
      press_pulse_q <= press_pulse_d;
      press_count_q <= press_count_d;
    end
  end

`ifdef PB_PRESS_DOUBLE_EN
  localparam logic [0:0]       ST_IDLE    = 1'b0;
  localparam logic [0:0]       ST_WAIT    = 1'b1;
  localparam logic [WIN_W-1:0] TIMER_LAST = WIN_W'(WINDOW_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [WIN_W-1:0] timer_q, timer_d;

  always_ff @(posedge clk_16M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (ev) begin
          state_d = ST_WAIT;
          timer_d = '0;
        end
      end
      ST_WAIT: begin
        // A second press wins over window expiry in the same cycle.
        if (ev) begin
          state_d = ST_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + WIN_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    single_press_d = 1'b0;
    double_press_d = 1'b0;
    if (state_q == ST_WAIT) begin
      double_press_d = ev;
      single_press_d = !ev && (timer_q == TIMER_LAST);
    end
  end
`else
  always_comb begin
    single_press_d = ev;
    double_press_d = 1'b0;
  end
`endif

  always_ff @(posedge clk_16M or negedge rst_n) begin
    if (!rst_n) begin
      single_press_q <= 1'b0;
      double_press_q <= 1'b0;
    end else begin
      single_press_q <= single_press_d;
      double_press_q <= double_press_d;
    end
  end

  assign press_pulse  = press_pulse_q;
  assign press_count  = press_count_q;
  assign single_press = single_press_q;
  assign double_press = double_press_q;

endmodule

`default_nettype wire

// File: tb/tb_pb_press_decoder.sv
// ============================================================================
// Module  : tb_pb_press_decoder
// Brief   : Directed bench for pb_press_decoder (WINDOW_CYCLES=16, CNT_W=4);
//           expectations follow PB_PRESS_DOUBLE_EN as compiled.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pb_press_decoder;

  localparam int WIN   = 16;
  localparam int WW    = 5;
  localparam int CW    = 4;

  logic          clk_16M = 1'b0;
  logic          rst_n;
  logic          set_rst_flag;
  logic          press_pulse;
  logic          single_press;
  logic          double_press;
  logic [CW-1:0] press_count;

  int n_cmp  = 0;
  int n_fail = 0;

  int tg[$];
  int pp[$];
  int sp[$];
  int dp[$];

  pb_press_decoder #(
    .WINDOW_CYCLES(WIN),
    .WIN_W        (WW),
    .CNT_W        (CW)
  ) dut (
    .clk_16M     (clk_16M),
    .rst_n       (rst_n),
    .set_rst_flag(set_rst_flag),
    .press_pulse (press_pulse),
    .single_press(single_press),
    .double_press(double_press),
    .press_count (press_count)
  );

  always #31 clk_16M = ~clk_16M;

  task automatic tick();
    @(posedge clk_16M);
    #1;
  endtask

  function automatic bit has(input int q[$], input int v);
    bit r = 1'b0;
    foreach (q[i]) if (q[i] == v) r = 1'b1;
    return r;
  endfunction

  function automatic int count_upto(input int q[$], input int v);
    int c = 0;
    foreach (q[i]) if (q[i] <= v) c++;
    return c;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e, input int pe,
                         input int se, input int de, input int ce);
    chk($sformatf("%s pulse@%0d", tag, e),  int'(press_pulse),  pe);
    chk($sformatf("%s single@%0d", tag, e), int'(single_press), se);
    chk($sformatf("%s double@%0d", tag, e), int'(double_press), de);
    chk($sformatf("%s count@%0d", tag, e),  int'(press_count),  ce);
  endtask

  // Reset with the given flag level; edge 0 is the edge just before release.
  task automatic do_reset(input logic flag);
    rst_n        = 1'b0;
    set_rst_flag = flag;
    tick();
    tick();
    chk_all("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  // Toggle the flag so s1 sees it at each edge in tg; check every edge 1..n.
  task automatic run(input string tag, input int n);
    for (int e = 1; e <= n; e++) begin
      if (has(tg, e)) set_rst_flag = ~set_rst_flag;
      tick();
      chk_all(tag, e, int'(has(pp, e)), int'(has(sp, e)), int'(has(dp, e)),
              count_upto(pp, e) % 16);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    set_rst_flag = 1'b0;

    // Single press
    do_reset(1'b0);
    tg = '{10}; pp = '{11}; dp = '{};
`ifdef PB_PRESS_DOUBLE_EN
    sp = '{27};
`else
    sp = '{11};
`endif
    run("single", 50);

    // Double press inside the window
    do_reset(1'b0);
    tg = '{10, 20}; pp = '{11, 21};
`ifdef PB_PRESS_DOUBLE_EN
    sp = '{}; dp = '{21};
`else
    sp = '{11, 21}; dp = '{};
`endif
    run("double", 50);

    // Second press exactly on window expiry: double wins
    do_reset(1'b0);
    tg = '{10, 26}; pp = '{11, 27};
`ifdef PB_PRESS_DOUBLE_EN
    sp = '{}; dp = '{27};
`else
    sp = '{11, 27}; dp = '{};
`endif
    run("tie", 50);

    // Flag high through reset must not count as a press
    do_reset(1'b1);
    tg = '{}; pp = '{}; sp = '{}; dp = '{};
    run("prime", 100);

    // 17 isolated presses wrap the 4-bit counter to 1
    do_reset(1'b0);
    tg = '{}; pp = '{}; sp = '{}; dp = '{};
    for (int i = 0; i < 17; i++) begin
      tg.push_back(10 + 40 * i);
      pp.push_back(11 + 40 * i);
`ifdef PB_PRESS_DOUBLE_EN
      sp.push_back(27 + 40 * i);
`else
      sp.push_back(11 + 40 * i);
`endif
    end
    run("wrap", 17 * 40 + 20);
    chk("wrap final count", int'(press_count), 1);

    // Reset asserted while waiting for a second press
    do_reset(1'b0);
    tg = '{10}; pp = '{11}; dp = '{};
`ifdef PB_PRESS_DOUBLE_EN
    sp = '{};
`else
    sp = '{11};
`endif
    run("midwait", 15);
    rst_n = 1'b0;
    #1;
    chk_all("midwait async", 15, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    tg = '{}; pp = '{}; sp = '{}; dp = '{};
    run("after reset", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
